// File: rtl/axi_lite_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_wr_arbiter
// Purpose  : Round-robin arbiter that lets NUMBER_MASTER AXI-Lite write masters
//            share one slave port, with one outstanding write at a time.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_wr_arbiter #(
    parameter int                        NUMBER_MASTER   = 2,
    parameter int                        AXI_DATA_WIDTH  = 32,
    parameter int                        AXI_ADDR_WIDTH  = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET = 32'h1000_0000,
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE  = 32'h0000_FFFF
) (
    input  logic                                      aclk,
    input  logic                                      areset,
    // upstream masters
    input  logic [NUMBER_MASTER*AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [NUMBER_MASTER-1:0]                  s_axi_awvalid,
    output logic [NUMBER_MASTER-1:0]                  s_axi_awready,
    input  logic [NUMBER_MASTER*AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [NUMBER_MASTER*AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic [NUMBER_MASTER-1:0]                  s_axi_wvalid,
    output logic [NUMBER_MASTER-1:0]                  s_axi_wready,
    output logic [NUMBER_MASTER*2-1:0]                s_axi_bresp,
    output logic [NUMBER_MASTER-1:0]                  s_axi_bvalid,
    input  logic [NUMBER_MASTER-1:0]                  s_axi_bready,
    // downstream slave
    output logic [AXI_ADDR_WIDTH-1:0]                 m_axi_awaddr,
    output logic                                      m_axi_awvalid,
    input  logic                                      m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]                 m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]               m_axi_wstrb,
    output logic                                      m_axi_wvalid,
    input  logic                                      m_axi_wready,
    input  logic [1:0]                                m_axi_bresp,
    input  logic                                      m_axi_bvalid,
    output logic                                      m_axi_bready,
    // status
    output logic [NUMBER_MASTER-1:0]                  grant,
    output logic                                      busy
);

    localparam int c_STRB_W = AXI_DATA_WIDTH / 8;
    localparam int c_IDX_W  = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1;

    // One extra bit so OFFSET+RANGE cannot wrap past the top of the address space.
    localparam logic [AXI_ADDR_WIDTH:0] c_ADDR_LO = {1'b0, AXI_ADDR_OFFSET};
    localparam logic [AXI_ADDR_WIDTH:0] c_ADDR_HI = {1'b0, AXI_ADDR_OFFSET} + {1'b0, AXI_ADDR_RANGE};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [NUMBER_MASTER-1:0]   r_grant;
    logic [NUMBER_MASTER-1:0]   w_grant_nxt;
    logic [c_IDX_W-1:0]         r_gidx;
    logic [c_IDX_W-1:0]         w_gidx_nxt;
    logic [c_IDX_W-1:0]         r_rr_ptr;
    logic [c_IDX_W-1:0]         w_rr_ptr_nxt;
    logic                       r_aw_done;
    logic                       w_aw_done_nxt;
    logic                       r_w_done;
    logic                       w_w_done_nxt;

    logic [NUMBER_MASTER-1:0]   w_req;
    logic                       w_found;
    logic [c_IDX_W-1:0]         w_pick;
    logic                       w_aw_hs;
    logic                       w_w_hs;
    logic                       w_b_hs;

    generate
        for (genvar gi = 0; gi < NUMBER_MASTER; gi++) begin : g_req
            logic [AXI_ADDR_WIDTH:0] w_addr_ext;
            assign w_addr_ext = {1'b0, s_axi_awaddr[gi*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH]};
            assign w_req[gi]  = s_axi_awvalid[gi] &&
                                (w_addr_ext >= c_ADDR_LO) && (w_addr_ext <= c_ADDR_HI);
        end
    endgenerate

    // First requester at or after the round-robin pointer, in cyclic order.
    always_comb begin
        int v_idx;
        w_found = 1'b0;
        w_pick  = '0;
        v_idx   = 0;
        for (int k = 0; k < NUMBER_MASTER; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NUMBER_MASTER) begin
                v_idx = v_idx - NUMBER_MASTER;
            end
            if (!w_found && w_req[v_idx]) begin
                w_found = 1'b1;
                w_pick  = c_IDX_W'(v_idx);
            end
        end
    end

    // Channel steering towards and from the granted master.
    always_comb begin
        m_axi_awaddr  = '0;
        m_axi_awvalid = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = '0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        s_axi_awready = '0;
        s_axi_wready  = '0;
        s_axi_bvalid  = '0;
        s_axi_bresp   = '0;
        for (int i = 0; i < NUMBER_MASTER; i++) begin
            if (r_grant[i]) begin
                m_axi_awaddr = s_axi_awaddr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                m_axi_wdata  = s_axi_wdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                m_axi_wstrb  = s_axi_wstrb[i*c_STRB_W +: c_STRB_W];
                if (r_state == ST_DATA) begin
                    m_axi_awvalid   = s_axi_awvalid[i] & ~r_aw_done;
                    s_axi_awready[i] = m_axi_awready & ~r_aw_done;
                    m_axi_wvalid    = s_axi_wvalid[i] & ~r_w_done;
                    s_axi_wready[i] = m_axi_wready & ~r_w_done;
                end
                if (r_state == ST_RESP) begin
                    s_axi_bvalid[i]       = m_axi_bvalid;
                    s_axi_bresp[i*2 +: 2] = m_axi_bresp;
                    m_axi_bready          = s_axi_bready[i];
                end
            end
        end
    end

    assign w_aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_w_hs  = m_axi_wvalid & m_axi_wready;
    assign w_b_hs  = m_axi_bvalid & m_axi_bready;

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_gidx_nxt    = r_gidx;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_grant_nxt         = '0;
                    w_grant_nxt[w_pick] = 1'b1;
                    w_gidx_nxt          = w_pick;
                    w_state_nxt         = ST_DATA;
                end
            end
            ST_DATA: begin
                // AW and W may finish in either order or together.
                w_aw_done_nxt = r_aw_done | w_aw_hs;
                w_w_done_nxt  = r_w_done | w_w_hs;
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (w_b_hs) begin
                    w_state_nxt   = ST_IDLE;
                    w_grant_nxt   = '0;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    w_rr_ptr_nxt  = (r_gidx == c_IDX_W'(NUMBER_MASTER - 1)) ? '0 : r_gidx + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_rr_ptr  <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_gidx    <= w_gidx_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
        end
    end

    assign grant = r_grant;
    assign busy  = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_wr_arbiter
// Purpose  : Scoreboard bench for axi_lite_wr_arbiter with master/slave models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_wr_arbiter;

    localparam int NM = 2;
    localparam int DW = 32;
    localparam int AW = 32;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    logic [NM*AW-1:0]   s_axi_awaddr;
    logic [NM-1:0]      s_axi_awvalid, s_axi_awready;
    logic [NM*DW-1:0]   s_axi_wdata;
    logic [NM*DW/8-1:0] s_axi_wstrb;
    logic [NM-1:0]      s_axi_wvalid, s_axi_wready;
    logic [NM*2-1:0]    s_axi_bresp;
    logic [NM-1:0]      s_axi_bvalid, s_axi_bready;
    logic [AW-1:0]      m_axi_awaddr;
    logic               m_axi_awvalid, m_axi_awready;
    logic [DW-1:0]      m_axi_wdata;
    logic [DW/8-1:0]    m_axi_wstrb;
    logic               m_axi_wvalid, m_axi_wready;
    logic [1:0]         m_axi_bresp;
    logic               m_axi_bvalid, m_axi_bready;
    logic [NM-1:0]      grant;
    logic               busy;

    // second instance placed at the very top of the address space
    logic [NM*AW-1:0]   hi_s_awaddr;
    logic [NM-1:0]      hi_s_awvalid, hi_s_awready;
    logic [NM*DW-1:0]   hi_s_wdata;
    logic [NM*DW/8-1:0] hi_s_wstrb;
    logic [NM-1:0]      hi_s_wvalid, hi_s_wready;
    logic [NM*2-1:0]    hi_s_bresp;
    logic [NM-1:0]      hi_s_bvalid, hi_s_bready;
    logic [AW-1:0]      hi_m_awaddr;
    logic               hi_m_awvalid, hi_m_awready;
    logic [DW-1:0]      hi_m_wdata;
    logic [DW/8-1:0]    hi_m_wstrb;
    logic               hi_m_wvalid, hi_m_wready;
    logic [1:0]         hi_m_bresp;
    logic               hi_m_bvalid, hi_m_bready;
    logic [NM-1:0]      hi_grant;
    logic               hi_busy;

    axi_lite_wr_arbiter #(
        .NUMBER_MASTER(NM), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW),
        .AXI_ADDR_OFFSET(32'h1000_0000), .AXI_ADDR_RANGE(32'h0000_FFFF)
    ) u_dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .grant(grant), .busy(busy)
    );

    axi_lite_wr_arbiter #(
        .NUMBER_MASTER(NM), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW),
        .AXI_ADDR_OFFSET(32'hFFFF_0000), .AXI_ADDR_RANGE(32'h0000_FFFF)
    ) u_dut_hi (
        .aclk(aclk), .areset(areset),
        .s_axi_awaddr(hi_s_awaddr), .s_axi_awvalid(hi_s_awvalid), .s_axi_awready(hi_s_awready),
        .s_axi_wdata(hi_s_wdata), .s_axi_wstrb(hi_s_wstrb), .s_axi_wvalid(hi_s_wvalid),
        .s_axi_wready(hi_s_wready), .s_axi_bresp(hi_s_bresp), .s_axi_bvalid(hi_s_bvalid),
        .s_axi_bready(hi_s_bready),
        .m_axi_awaddr(hi_m_awaddr), .m_axi_awvalid(hi_m_awvalid), .m_axi_awready(hi_m_awready),
        .m_axi_wdata(hi_m_wdata), .m_axi_wstrb(hi_m_wstrb), .m_axi_wvalid(hi_m_wvalid),
        .m_axi_wready(hi_m_wready), .m_axi_bresp(hi_m_bresp), .m_axi_bvalid(hi_m_bvalid),
        .m_axi_bready(hi_m_bready),
        .grant(hi_grant), .busy(hi_busy)
    );

    typedef struct {
        int          master;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          n_aw = 0;
    int          n_w = 0;
    bit          aw_seen = 1'b0;
    bit          w_seen = 1'b0;
    logic [31:0] cap_addr, cap_data;
    logic [3:0]  cap_strb;

    // Master request: hold valids until each handshake; expected result queued now.
    task automatic issue(input int m, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input bit expect_grant);
        exp_t e;
        s_axi_awaddr[m*AW +: AW] = addr;
        s_axi_wdata[m*DW +: DW]  = data;
        s_axi_wstrb[m*4 +: 4]    = strb;
        s_axi_awvalid[m]         = 1'b1;
        s_axi_wvalid[m]          = 1'b1;
        if (expect_grant) begin
            e.master = m; e.addr = addr; e.data = data; e.strb = strb; e.resp = m_axi_bresp;
            exp_q.push_back(e);
        end
    endtask

    task automatic drop(input int m);
        s_axi_awvalid[m] = 1'b0;
        s_axi_wvalid[m]  = 1'b0;
    endtask

    // One clock: sample just after input changes, cross the edge, then update models.
    task automatic cycle();
        logic [NM-1:0] aw_hs, w_hs;
        logic          b_hs;
        exp_t          e;
        #1;
        aw_hs = s_axi_awvalid & s_axi_awready;
        w_hs  = s_axi_wvalid & s_axi_wready;
        b_hs  = m_axi_bvalid & m_axi_bready;
        checks++;
        if (((s_axi_awready | s_axi_wready | s_axi_bvalid) & ~grant) !== '0) begin
            errors++;
            $display("FAIL nongrant_quiet: awready=%b wready=%b bvalid=%b grant=%b, required zero off-grant",
                     s_axi_awready, s_axi_wready, s_axi_bvalid, grant);
        end
        if (m_axi_awvalid && m_axi_awready) begin
            cap_addr = m_axi_awaddr; n_aw++; aw_seen = 1'b1;
        end
        if (m_axi_wvalid && m_axi_wready) begin
            cap_data = m_axi_wdata; cap_strb = m_axi_wstrb; n_w++; w_seen = 1'b1;
        end
        if (b_hs) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_b: got bvalid=%b, required no response", s_axi_bvalid);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (s_axi_bvalid !== (2'b01 << e.master)) begin
                    errors++;
                    $display("FAIL sb_bvalid_master: got %b, required master %0d", s_axi_bvalid, e.master);
                end
                checks++;
                if (cap_addr !== e.addr) begin
                    errors++;
                    $display("FAIL sb_awaddr: got %h, required %h", cap_addr, e.addr);
                end
                checks++;
                if (cap_data !== e.data || cap_strb !== e.strb) begin
                    errors++;
                    $display("FAIL sb_wdata: got %h/%h, required %h/%h", cap_data, cap_strb, e.data, e.strb);
                end
                checks++;
                if (s_axi_bresp[e.master*2 +: 2] !== e.resp) begin
                    errors++;
                    $display("FAIL sb_bresp: got %b, required %b", s_axi_bresp[e.master*2 +: 2], e.resp);
                end
            end
        end
        @(negedge aclk);
        s_axi_awvalid = s_axi_awvalid & ~aw_hs;
        s_axi_wvalid  = s_axi_wvalid & ~w_hs;
        if (b_hs) begin
            m_axi_bvalid = 1'b0; aw_seen = 1'b0; w_seen = 1'b0;
        end else if (aw_seen && w_seen) begin
            m_axi_bvalid = 1'b1;
        end
    endtask

    task automatic wait_idle(input string name, input int budget, output int used);
        used = 0;
        while ((exp_q.size() != 0 || busy || m_axi_bvalid) && used < budget) begin
            cycle();
            used++;
        end
        checks++;
        if (busy || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b pending=%0d after %0d cycles, required idle", name, busy,
                     exp_q.size(), used);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = '0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = '0; s_axi_bready = '1;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
        hi_s_awaddr = '0; hi_s_awvalid = '0; hi_s_wdata = '0; hi_s_wstrb = '0; hi_s_wvalid = '0;
        hi_s_bready = '1; hi_m_awready = 1'b0; hi_m_wready = 1'b0; hi_m_bresp = 2'b00; hi_m_bvalid = 1'b0;
        @(negedge aclk);
        issue(0, 32'h1000_0000, 32'h0, 4'hF, 1'b0);
        cycle(); cycle();
        checks++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: grant=%b busy=%b, required 00/0", grant, busy);
        end
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axi_awready, s_axi_wready, s_axi_bvalid} !== '0) begin
            errors++;
            $display("FAIL reset_handshakes: awv=%b wv=%b bready=%b awr=%b wr=%b bv=%b, required all 0",
                     m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axi_awready, s_axi_wready, s_axi_bvalid);
        end
        drop(0);
        areset = 1'b0;
        cycle();
    endtask

    task automatic test_single();
        int used;
        m_axi_bresp = 2'b00;
        issue(0, 32'h1000_0010, 32'hA5A5_A5A5, 4'hF, 1'b1);
        cycle();
        checks++;
        if (grant !== 2'b01 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: grant=%b busy=%b, required 01/1", grant, busy);
        end
        checks++;
        if (m_axi_awaddr !== 32'h1000_0010) begin
            errors++;
            $display("FAIL single_awaddr: got %h, required 10000010", m_axi_awaddr);
        end
        wait_idle("single", 20, used);
        checks++;
        if (used + 1 != 3) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles, required 3", used + 1);
        end
        checks++;
        if (grant !== 2'b00) begin
            errors++;
            $display("FAIL single_idle_grant: got %b, required 00", grant);
        end
    endtask

    task automatic test_back_to_back();
        int used;
        areset = 1'b1; cycle(); areset = 1'b0;
        m_axi_bresp = 2'b10;
        issue(0, 32'h1000_0000, 32'h0000_0A0A, 4'hF, 1'b1);
        issue(1, 32'h1000_0000, 32'h0000_0B0B, 4'h1, 1'b1);
        wait_idle("b2b", 40, used);
        checks++;
        if (used != 6) begin
            errors++;
            $display("FAIL b2b_cycles: got %0d, required 6", used);
        end
    endtask

    task automatic test_round_robin();
        int used;
        m_axi_bresp = 2'b01;
        issue(0, 32'h1000_0040, 32'h0000_0C0C, 4'hF, 1'b1);
        wait_idle("rr_prime", 20, used);
        // last served was M0, so M1 now has priority
        issue(1, 32'h1000_0044, 32'h0000_1111, 4'hF, 1'b1);
        issue(0, 32'h1000_0048, 32'h0000_2222, 4'hF, 1'b1);
        cycle();
        checks++;
        if (grant !== 2'b10) begin
            errors++;
            $display("FAIL rr_grant_m1: got %b, required 10", grant);
        end
        wait_idle("rr", 40, used);
        m_axi_bresp = 2'b00;
    endtask

    task automatic test_out_of_range();
        int bad = 0;
        issue(1, 32'h2000_0000, 32'hFFFF_FFFF, 4'hF, 1'b0);
        for (int i = 0; i < 100; i++) begin
            cycle();
            checks++;
            if (grant !== 2'b00 || s_axi_awready[1] !== 1'b0 || busy !== 1'b0) begin
                errors++; bad++;
                if (bad < 4)
                    $display("FAIL oor_no_grant: cycle %0d grant=%b awready1=%b busy=%b, required 00/0/0",
                             i, grant, s_axi_awready[1], busy);
            end
        end
        drop(1);
    endtask

    task automatic test_w_before_aw();
        int used;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        n_aw = 0; n_w = 0;
        issue(0, 32'h1000_0100, 32'h1234_5678, 4'h3, 1'b1);
        cycle();
        m_axi_wready = 1'b1;
        repeat (5) cycle();
        checks++;
        if (n_w != 1 || n_aw != 0 || m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b0 || m_axi_bready !== 1'b0) begin
            errors++;
            $display("FAIL wfirst_pending: w=%0d aw=%0d awv=%b wv=%b bready=%b, required 1/0/1/0/0",
                     n_w, n_aw, m_axi_awvalid, m_axi_wvalid, m_axi_bready);
        end
        m_axi_awready = 1'b1;
        cycle();
        checks++;
        if (n_aw != 1 || m_axi_bready !== 1'b1 || m_axi_awvalid !== 1'b0) begin
            errors++;
            $display("FAIL wfirst_resp: aw=%0d bready=%b awv=%b, required 1/1/0", n_aw, m_axi_bready, m_axi_awvalid);
        end
        wait_idle("wfirst", 20, used);
        checks++;
        if (n_aw != 1 || n_w != 1) begin
            errors++;
            $display("FAIL wfirst_counts: aw=%0d w=%0d, required 1/1", n_aw, n_w);
        end
        m_axi_awready = 1'b0; m_axi_wready = 1'b0;
        n_aw = 0; n_w = 0;
        issue(1, 32'h1000_0104, 32'h8765_4321, 4'h8, 1'b1);
        cycle(); cycle();
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        cycle();
        checks++;
        if (n_aw != 1 || n_w != 1 || m_axi_bready !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_hs: aw=%0d w=%0d bready=%b, required 1/1/1", n_aw, n_w, m_axi_bready);
        end
        wait_idle("same", 20, used);
    endtask

    task automatic test_reset_mid();
        int used;
        m_axi_awready = 1'b1; m_axi_wready = 1'b0;
        n_aw = 0;
        issue(0, 32'h1000_0200, 32'hDEAD_BEEF, 4'hF, 1'b0);
        cycle(); cycle();
        checks++;
        if (n_aw != 1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_setup: aw=%0d busy=%b, required 1/1", n_aw, busy);
        end
        areset = 1'b1;
        cycle();
        areset = 1'b0;
        checks++;
        if (busy !== 1'b0 || grant !== 2'b00 || m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b0 ||
            s_axi_bvalid !== 2'b00 || m_axi_bready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle: busy=%b grant=%b awv=%b wv=%b bv=%b bready=%b, required all 0",
                     busy, grant, m_axi_awvalid, m_axi_wvalid, s_axi_bvalid, m_axi_bready);
        end
        drop(0);
        aw_seen = 1'b0; w_seen = 1'b0; m_axi_bvalid = 1'b0;
        m_axi_wready = 1'b1;
        issue(1, 32'h1000_0300, 32'h0BAD_F00D, 4'hC, 1'b1);
        wait_idle("midrst_fresh", 20, used);
    endtask

    task automatic test_boundary();
        int used;
        issue(0, 32'h1000_FFFF, 32'h1111_2222, 4'hF, 1'b1);
        cycle();
        checks++;
        if (grant !== 2'b01) begin
            errors++;
            $display("FAIL bound_top_in: grant=%b, required 01", grant);
        end
        wait_idle("bound_top", 20, used);
        issue(1, 32'h1001_0000, 32'h0, 4'hF, 1'b0);
        repeat (3) cycle();
        checks++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bound_above: grant=%b busy=%b, required 00/0", grant, busy);
        end
        drop(1);
        issue(0, 32'h0FFF_FFFF, 32'h0, 4'hF, 1'b0);
        repeat (3) cycle();
        checks++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bound_below: grant=%b busy=%b, required 00/0", grant, busy);
        end
        drop(0);
        hi_s_awaddr[AW-1:0] = 32'hFFFF_FFFF; hi_s_awvalid = 2'b01;
        cycle();
        checks++;
        if (hi_grant !== 2'b01) begin
            errors++;
            $display("FAIL bound_no_wrap: hi grant=%b, required 01", hi_grant);
        end
        hi_s_awvalid = 2'b00;
        areset = 1'b1; cycle(); areset = 1'b0;
        hi_s_awaddr[AW-1:0] = 32'hFFFE_FFFF; hi_s_awvalid = 2'b01;
        cycle(); cycle();
        checks++;
        if (hi_grant !== 2'b00) begin
            errors++;
            $display("FAIL bound_hi_below: hi grant=%b, required 00", hi_grant);
        end
        hi_s_awvalid = 2'b00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_round_robin();
        test_out_of_range();
        test_w_before_aw();
        test_reset_mid();
        test_boundary();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected writes never completed, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
